// File: rtl/spi_capture_pkg.sv
// Shared types and constants for the SPI frame capture controller:
// FSM state encoding, per-buffer occupancy state and buffer count.
package spi_capture_pkg;

  // Number of ping-pong frame buffers; buffer index is one bit wide.
  localparam int NUM_BUFS  = 2;
  localparam int BUF_IDX_W = 1;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DROP    = 2'd2,
    ST_OVERRUN = 2'd3
  } capture_state_t;

  // Occupancy of one frame buffer.
  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by one edge
// register; emits single-cycle rise/fall pulses on the synchronized level.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync_1;
  logic r_sync_2;
  logic r_edge_prev;

  // Metastability chain plus one-cycle-delayed copy for edge comparison.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_1    <= RESET_VAL;
      r_sync_2    <= RESET_VAL;
      r_edge_prev <= RESET_VAL;
    end else begin
      r_sync_1    <= i_async;
      r_sync_2    <= r_sync_1;
      r_edge_prev <= r_sync_2;
    end
  end

  assign o_rise = r_sync_2 & ~r_edge_prev;
  assign o_fall = ~r_sync_2 & r_edge_prev;

endmodule

// File: rtl/spi_frame_capture_ctrl.sv
// Sequences pixels from the SPI receiver into two ping-pong frame buffers,
// framing on chip-select, and queues completed frames for the consumer.
// Optional macro FRAME_STATS_EN adds saturating good/bad frame counters.
module spi_frame_capture_ctrl
  import spi_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_WIDTH = $clog2(H_RES*V_RES)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  chip_sel_in,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid_in,
  output logic                  wr_en_out,
  output logic                  wr_buf_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [DATA_WIDTH-1:0] wr_data_out,
  output logic                  frame_ready_out,
  output logic                  frame_buf_out,
  input  logic                  frame_ack_in,
  output logic                  frame_done_out,
  output logic                  frame_err_out
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]           frames_ok_out,
  output logic [15:0]           frames_err_out
`endif
);

  localparam int FRAME_PIXELS = H_RES * V_RES;
  // One extra state beyond the last address: "count reached frame size".
  localparam int CNT_WIDTH    = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_WIDTH-1:0] LP_FRAME_PIX = CNT_WIDTH'(FRAME_PIXELS);

  // CS edge pulses from the synchronizer; CS idles high.
  logic w_cs_rise;
  logic w_cs_fall;

  sync_edge_detect #(
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_async (chip_sel_in),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // Sequencer and frame bookkeeping registers.
  capture_state_t        r_state;
  capture_state_t        w_state_next;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_next;
  logic [BUF_IDX_W-1:0]  r_cur_buf;
  logic [BUF_IDX_W-1:0]  w_cur_buf_next;
  logic                  r_long;
  logic                  w_long_next;

  buf_state_t            r_buf_state      [NUM_BUFS];
  buf_state_t            w_buf_state_next [NUM_BUFS];
  logic [NUM_BUFS-1:0]   w_buf_free;

  // Completed-frame FIFO: slot 0 is the head.
  logic [BUF_IDX_W-1:0]  r_fifo      [NUM_BUFS];
  logic [BUF_IDX_W-1:0]  w_fifo_next [NUM_BUFS];
  logic [1:0]            r_fifo_cnt;
  logic [1:0]            w_fifo_cnt_next;

  // Registered write port and status pulses.
  logic                  r_wr_en;
  logic                  w_wr_en_next;
  logic                  r_wr_buf;
  logic                  w_wr_buf_next;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr_next;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] w_wr_data_next;
  logic                  r_frame_done;
  logic                  w_done_next;
  logic                  r_frame_err;
  logic                  w_err_next;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_any_free;
  logic [BUF_IDX_W-1:0]  w_free_idx;

  genvar gi;

  // Per-buffer free flags for allocation.
  generate
    for (gi = 0; gi < NUM_BUFS; gi++) begin : g_free
      assign w_buf_free[gi] = (r_buf_state[gi] == BUF_FREE);
    end
  endgenerate

  assign w_any_free = |w_buf_free;
  assign w_free_idx = w_buf_free[0] ? 1'b0 : 1'b1;

  // Next-state logic: frame sequencing, buffer states, write port, FIFO.
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_cur_buf_next = r_cur_buf;
    w_long_next    = r_long;
    for (int i = 0; i < NUM_BUFS; i++) begin
      w_buf_state_next[i] = r_buf_state[i];
      w_fifo_next[i]      = r_fifo[i];
    end
    w_fifo_cnt_next = r_fifo_cnt;
    w_wr_en_next    = 1'b0;
    w_wr_buf_next   = r_wr_buf;
    w_wr_addr_next  = r_wr_addr;
    w_wr_data_next  = r_wr_data;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
    w_push          = 1'b0;
    w_pop           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Allocation looks at pre-ack state; a buffer freed this cycle
        // becomes available from the next frame on.
        if (w_cs_fall) begin
          if (w_any_free) begin
            w_buf_state_next[w_free_idx] = BUF_FILLING;
            w_cur_buf_next               = w_free_idx;
            w_count_next                 = '0;
            w_long_next                  = 1'b0;
            w_state_next                 = ST_CAPTURE;
          end else begin
            w_state_next = ST_DROP;
          end
        end
      end

      ST_CAPTURE: begin
        if (pixel_valid_in) begin
          w_wr_en_next   = 1'b1;
          w_wr_buf_next  = r_cur_buf;
          w_wr_addr_next = r_count[ADDR_WIDTH-1:0];
          w_wr_data_next = pixel_in;
          w_count_next   = r_count + CNT_WIDTH'(1);
        end
        if (w_cs_rise) begin
          if (w_count_next == LP_FRAME_PIX) begin
            w_buf_state_next[r_cur_buf] = BUF_FULL;
            w_push                      = 1'b1;
            w_done_next                 = 1'b1;
          end else begin
            // Short frame: discard and release the buffer.
            w_buf_state_next[r_cur_buf] = BUF_FREE;
            w_err_next                  = 1'b1;
          end
          w_state_next = ST_IDLE;
        end else if (w_count_next == LP_FRAME_PIX) begin
          w_state_next = ST_OVERRUN;
        end
      end

      ST_OVERRUN: begin
        // Frame is complete; extra pixels only mark the frame as long.
        if (pixel_valid_in) begin
          w_long_next = 1'b1;
        end
        if (w_cs_rise) begin
          w_buf_state_next[r_cur_buf] = BUF_FULL;
          w_push                      = 1'b1;
          w_done_next                 = 1'b1;
          w_err_next                  = w_long_next;
          w_state_next                = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (w_cs_rise) begin
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Consumer release of the head frame; ignored when nothing is queued.
    w_pop = frame_ack_in && (r_fifo_cnt != 2'd0);
    if (w_pop) begin
      w_buf_state_next[r_fifo[0]] = BUF_FREE;
    end

    // FIFO update; simultaneous pop and push keep the count.
    if (w_push && w_pop) begin
      if (r_fifo_cnt == 2'd1) begin
        w_fifo_next[0] = r_cur_buf;
      end else begin
        w_fifo_next[0] = r_fifo[1];
        w_fifo_next[1] = r_cur_buf;
      end
    end else if (w_push) begin
      if (r_fifo_cnt == 2'd0) begin
        w_fifo_next[0] = r_cur_buf;
      end else begin
        w_fifo_next[1] = r_cur_buf;
      end
      w_fifo_cnt_next = r_fifo_cnt + 2'd1;
    end else if (w_pop) begin
      w_fifo_next[0]  = r_fifo[1];
      w_fifo_cnt_next = r_fifo_cnt - 2'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame bookkeeping, write port and status pulse registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_count      <= '0;
      r_cur_buf    <= '0;
      r_long       <= 1'b0;
      r_fifo_cnt   <= 2'd0;
      r_wr_en      <= 1'b0;
      r_wr_buf     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_count      <= w_count_next;
      r_cur_buf    <= w_cur_buf_next;
      r_long       <= w_long_next;
      r_fifo_cnt   <= w_fifo_cnt_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_buf     <= w_wr_buf_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_frame_done <= w_done_next;
      r_frame_err  <= w_err_next;
    end
  end

  // Per-buffer occupancy state and FIFO slot registers.
  generate
    for (gi = 0; gi < NUM_BUFS; gi++) begin : g_buf_regs
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          r_buf_state[gi] <= BUF_FREE;
          r_fifo[gi]      <= '0;
        end else begin
          r_buf_state[gi] <= w_buf_state_next[gi];
          r_fifo[gi]      <= w_fifo_next[gi];
        end
      end
    end
  endgenerate

  assign wr_en_out       = r_wr_en;
  assign wr_buf_out      = r_wr_buf;
  assign wr_addr_out     = r_wr_addr;
  assign wr_data_out     = r_wr_data;
  assign frame_ready_out = (r_fifo_cnt != 2'd0);
  assign frame_buf_out   = r_fifo[0];
  assign frame_done_out  = r_frame_done;
  assign frame_err_out   = r_frame_err;

`ifdef FRAME_STATS_EN
  logic [15:0] r_frames_ok;
  logic [15:0] r_frames_err;

  // Saturating tallies of emitted done/error pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frames_ok  <= 16'd0;
      r_frames_err <= 16'd0;
    end else begin
      if (r_frame_done && (r_frames_ok != 16'hFFFF)) begin
        r_frames_ok <= r_frames_ok + 16'd1;
      end
      if (r_frame_err && (r_frames_err != 16'hFFFF)) begin
        r_frames_err <= r_frames_err + 16'd1;
      end
    end
  end

  assign frames_ok_out  = r_frames_ok;
  assign frames_err_out = r_frames_err;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_spi_frame_capture_ctrl.sv
// Directed bench for spi_frame_capture_ctrl with a 4x2 frame (8 pixels).
module tb_spi_frame_capture_ctrl;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs    = 1'b1;
  logic [DW-1:0] pix   = '0;
  logic          pv    = 1'b0;
  logic          ack   = 1'b0;

  logic          wr_en;
  logic          wr_buf;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          ready;
  logic          head;
  logic          done;
  logic          err;
`ifdef FRAME_STATS_EN
  logic [15:0]   frames_ok;
  logic [15:0]   frames_err;
`endif

  spi_frame_capture_ctrl #(
    .DATA_WIDTH (DW),
    .H_RES      (H),
    .V_RES      (V),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .chip_sel_in     (cs),
    .pixel_in        (pix),
    .pixel_valid_in  (pv),
    .wr_en_out       (wr_en),
    .wr_buf_out      (wr_buf),
    .wr_addr_out     (wr_addr),
    .wr_data_out     (wr_data),
    .frame_ready_out (ready),
    .frame_buf_out   (head),
    .frame_ack_in    (ack),
    .frame_done_out  (done),
    .frame_err_out   (err)
`ifdef FRAME_STATS_EN
    ,
    .frames_ok_out   (frames_ok),
    .frames_err_out  (frames_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int        npix;
    logic [7:0] base;
    bit        ack_before;
    int        exp_writes;
    bit        exp_buf;
    int        exp_done;
    int        exp_err;
    int        exp_both;
    bit        exp_ready;
    bit        exp_head;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;

  logic [11:0] wr_log [$];
  int done_n = 0;
  int err_n  = 0;
  int both_n = 0;

  // Observe DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({wr_buf, wr_addr, wr_data});
    if (done) done_n++;
    if (err) err_n++;
    if (done && err) both_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    if (v.ack_before) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
    end
    wr_log.delete();
    done_n = 0;
    err_n  = 0;
    both_n = 0;
    cs = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < v.npix; i++) begin
      pix = v.base + 8'(i);
      pv  = 1'b1;
      tick();
      pv  = 1'b0;
      tick();
    end
    tick();
    tick();
    cs = 1'b1;
    repeat (8) tick();
    check("wr_count", wr_log.size(), v.exp_writes);
    for (int i = 0; i < wr_log.size() && i < v.exp_writes; i++) begin
      check("wr_buf_addr_data", int'(wr_log[i]),
            int'({v.exp_buf, 3'(i), 8'(v.base + 8'(i))}));
    end
    check("done_pulses", done_n, v.exp_done);
    check("err_pulses", err_n, v.exp_err);
    check("done_err_same_cycle", both_n, v.exp_both);
    check("frame_ready", int'(ready), int'(v.exp_ready));
    if (v.exp_ready) check("frame_buf", int'(head), int'(v.exp_head));
    $display("frame %0d: npix=%0d base=0x%0h writes=%0d done=%0d err=%0d ready=%0d head=%0d",
             idx, v.npix, v.base, wr_log.size(), done_n, err_n, ready, head);
  endtask

  function automatic int all_outs();
    return int'({wr_en, wr_buf, wr_addr, wr_data, ready, head, done, err});
  endfunction

  initial begin
    //            npix base  ackb wr buf done err both rdy head
    vecs[0] = '{8,  8'h10, 0, 8, 0, 1, 0, 0, 1, 0};  // normal frame -> buf 0
    vecs[1] = '{8,  8'h20, 0, 8, 1, 1, 0, 0, 1, 0};  // ping-pong -> buf 1, head 0
    vecs[2] = '{8,  8'h30, 0, 0, 0, 0, 1, 0, 1, 0};  // both full -> dropped
    vecs[3] = '{5,  8'h40, 0, 5, 0, 0, 1, 0, 0, 0};  // short frame, buf 0 freed
    vecs[4] = '{10, 8'h50, 0, 8, 0, 1, 1, 1, 1, 0};  // long frame reuses buf 0
    vecs[5] = '{8,  8'h60, 1, 8, 0, 1, 0, 0, 1, 0};  // ack first, buf 0 again

    // Reset state.
    #2;
    check("reset_outputs", all_outs(), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_outputs", all_outs(), 0);

    for (int k = 0; k < 3; k++) run_frame(vecs[k], k);

    // Drain the FIFO by hand: head moves to buf 1, then empties.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack1_ready", int'(ready), 1);
    check("ack1_head", int'(head), 1);
    $display("ack 1: ready=%0d head=%0d", ready, head);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack2_ready", int'(ready), 0);
    $display("ack 2: ready=%0d head=%0d", ready, head);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_empty_ignored", int'(ready), 0);
    $display("ack 3 (empty): ready=%0d", ready);
    tick();

    for (int k = 3; k < 6; k++) run_frame(vecs[k], k);

    // Reset mid-frame: buf 0 is queued, new frame goes to buf 1.
    wr_log.delete();
    cs = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      pix = 8'h80 + 8'(i);
      pv  = 1'b1;
      tick();
      pv  = 1'b0;
      tick();
    end
    check("pre_reset_writes", wr_log.size(), 3);
    if (wr_log.size() > 0) check("pre_reset_buf", int'(wr_log[0][11]), 1);
    rst_n = 1'b0;
    #1;
    check("mid_frame_reset_outputs", all_outs(), 0);
    $display("reset mid-frame: outputs=0x%0h", all_outs());
    cs = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    begin
      vec_t v;
      v = '{8, 8'h70, 0, 8, 0, 1, 0, 0, 1, 0};
      run_frame(v, 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
